// File: rtl/frame_bank_scheduler.sv
// Double-buffered frame bank scheduler: startup white frames, first fill, then bank ping-pong on frame boundaries.
// Optional statistics (repeat_count, overrun) are built only when FRAME_STATS_EN is defined.
module frame_bank_scheduler #(
   parameter int STARTUP_FRAMES = 4,
   parameter int CNT_W          = 16
) (
   input  logic             CLK_40,
   input  logic             reset,
   input  logic             start,
   input  logic             frame_start,
   input  logic             frame_write_done,
   output logic             read_bank1,
   output logic             read_bank2,
   output logic             write_sel,
   output logic             write_ready,
   output logic             VGA_en,
   output logic             VGA_startup_en,
   output logic [CNT_W-1:0] repeat_count,
   output logic             overrun
);

   // state   | meaning
   // IDLE    | VGA off, no banks active, waiting for start
   // STARTUP | VGA on, forced white, counting down STARTUP_FRAMES frame boundaries
   // FILL    | still white, writer fills bank 1 for the first time
   // RUN     | display one bank, write the other, swap on frame_start when a new frame is pending

   typedef enum logic [1:0] {IDLE, STARTUP, FILL, RUN} state_t;

   localparam int SW = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;

   state_t        state, state_nxt;
   logic [SW-1:0] su_cnt, su_cnt_nxt;
   logic          pending, pending_nxt;
   logic          disp2, disp2_nxt;
   logic          rb1_nxt, rb2_nxt, ws_nxt, wr_nxt, ven_nxt, vsu_nxt;

   always_ff @(posedge CLK_40) begin
      if (!reset) begin
         state          <= IDLE;
         su_cnt         <= '0;
         pending        <= 1'b0;
         disp2          <= 1'b0;
         read_bank1     <= 1'b0;
         read_bank2     <= 1'b0;
         write_sel      <= 1'b0;
         write_ready    <= 1'b0;
         VGA_en         <= 1'b0;
         VGA_startup_en <= 1'b0;
      end else begin
         state          <= state_nxt;
         su_cnt         <= su_cnt_nxt;
         pending        <= pending_nxt;
         disp2          <= disp2_nxt;
         read_bank1     <= rb1_nxt;
         read_bank2     <= rb2_nxt;
         write_sel      <= ws_nxt;
         write_ready    <= wr_nxt;
         VGA_en         <= ven_nxt;
         VGA_startup_en <= vsu_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      su_cnt_nxt  = su_cnt;
      pending_nxt = pending;
      disp2_nxt   = disp2;
      if (!start) begin
         state_nxt   = IDLE;
         pending_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt  = STARTUP;
               su_cnt_nxt = SW'(STARTUP_FRAMES - 1);
            end
            STARTUP: begin
               if (frame_start) begin
                  if (su_cnt == '0) state_nxt = FILL;
                  else              su_cnt_nxt = su_cnt - SW'(1);
               end
            end
            FILL: begin
               if (frame_write_done) begin
                  state_nxt   = RUN;
                  disp2_nxt   = 1'b0;
                  pending_nxt = 1'b0;
               end
            end
            RUN: begin
               // a done arriving with frame_start counts as completed before the boundary
               if (frame_start && (pending || frame_write_done)) begin
                  disp2_nxt   = ~disp2;
                  pending_nxt = 1'b0;
               end else if (frame_write_done) begin
                  pending_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // outputs are decoded from the next state so they register together with it
   always_comb begin
      rb1_nxt = 1'b0;
      rb2_nxt = 1'b0;
      ws_nxt  = 1'b0;
      wr_nxt  = 1'b0;
      ven_nxt = 1'b0;
      vsu_nxt = 1'b0;
      case (state_nxt)
         STARTUP: begin
            ven_nxt = 1'b1;
            vsu_nxt = 1'b1;
         end
         FILL: begin
            ven_nxt = 1'b1;
            vsu_nxt = 1'b1;
            wr_nxt  = 1'b1;
         end
         RUN: begin
            ven_nxt = 1'b1;
            rb1_nxt = ~disp2_nxt;
            rb2_nxt = disp2_nxt;
            ws_nxt  = ~disp2_nxt;
            wr_nxt  = ~pending_nxt;
         end
         default: ;
      endcase
   end

`ifdef FRAME_STATS_EN
   logic rep_inc, ovr_set;

   assign rep_inc = (state == RUN) && start && frame_start && !frame_write_done && !pending;
   assign ovr_set = (state == RUN) && start && frame_write_done && pending;

   always_ff @(posedge CLK_40) begin
      if (!reset) begin
         repeat_count <= '0;
         overrun      <= 1'b0;
      end else begin
         if (rep_inc && (repeat_count != '1)) repeat_count <= repeat_count + CNT_W'(1);
         if (ovr_set)                         overrun      <= 1'b1;
      end
   end
`else
   assign repeat_count = '0;
   assign overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler; statistics expectations follow FRAME_STATS_EN.
`timescale 1ns/1ps
module tb_frame_bank_scheduler;

   localparam int CNT_W = 16;
`ifdef FRAME_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             CLK_40 = 1'b0;
   logic             reset, start, frame_start, frame_write_done;
   logic             read_bank1, read_bank2, write_sel, write_ready, VGA_en, VGA_startup_en;
   logic [CNT_W-1:0] repeat_count;
   logic             overrun;

   int n_chk = 0;
   int n_err = 0;

   // output vector order: {read_bank1, read_bank2, write_sel, write_ready, VGA_en, VGA_startup_en}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_START = 6'b000011;
   localparam logic [5:0] O_FILL  = 6'b000111;
   localparam logic [5:0] O_R1    = 6'b101110;
   localparam logic [5:0] O_R1P   = 6'b101010;
   localparam logic [5:0] O_R2    = 6'b010110;
   localparam logic [5:0] O_R2P   = 6'b010010;

   frame_bank_scheduler #(.STARTUP_FRAMES(4), .CNT_W(CNT_W)) dut (
      .CLK_40           (CLK_40),
      .reset            (reset),
      .start            (start),
      .frame_start      (frame_start),
      .frame_write_done (frame_write_done),
      .read_bank1       (read_bank1),
      .read_bank2       (read_bank2),
      .write_sel        (write_sel),
      .write_ready      (write_ready),
      .VGA_en           (VGA_en),
      .VGA_startup_en   (VGA_startup_en),
      .repeat_count     (repeat_count),
      .overrun          (overrun)
   );

   always #12.5 CLK_40 = ~CLK_40;

   task automatic cycle(input logic fs, input logic fwd);
      frame_start      = fs;
      frame_write_done = fwd;
      @(posedge CLK_40);
      #1;
      frame_start      = 1'b0;
      frame_write_done = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [5:0] exp_o, input int rep, input logic ovr);
      chk({tag, ".outs"}, 32'({read_bank1, read_bank2, write_sel, write_ready, VGA_en, VGA_startup_en}),
          32'(exp_o));
      chk({tag, ".rep"}, 32'(repeat_count), STATS ? 32'(rep) : 32'd0);
      chk({tag, ".ovr"}, 32'(overrun), STATS ? 32'(ovr) : 32'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; frame_start = 1'b0; frame_write_done = 1'b0;
      cycle(0, 0);
      cycle(0, 0);
      chk_all("reset", O_IDLE, 0, 0);

      reset = 1'b1; start = 1'b1;
      cycle(0, 0);  chk_all("startup_entry", O_START, 0, 0);
      cycle(0, 1);  chk_all("startup_ignore_done", O_START, 0, 0);
      cycle(1, 0);  chk_all("startup_p1", O_START, 0, 0);
      cycle(1, 0);  chk_all("startup_p2", O_START, 0, 0);
      cycle(1, 0);  chk_all("startup_p3", O_START, 0, 0);
      cycle(1, 0);  chk_all("fill_entry", O_FILL, 0, 0);
      cycle(1, 0);  chk_all("fill_ignore_fs", O_FILL, 0, 0);

      cycle(0, 1);  chk_all("run_entry", O_R1, 0, 0);
      cycle(0, 1);  chk_all("run_pending", O_R1P, 0, 0);
      cycle(1, 0);  chk_all("run_swap_b2", O_R2, 0, 0);

      cycle(1, 0);  chk_all("repeat1", O_R2, 1, 0);
      cycle(1, 0);  chk_all("repeat2", O_R2, 2, 0);
      cycle(1, 0);  chk_all("repeat3", O_R2, 3, 0);

      cycle(1, 1);  chk_all("same_cycle_swap", O_R1, 3, 0);

      cycle(0, 1);  chk_all("done_a", O_R1P, 3, 0);
      cycle(0, 1);  chk_all("done_b_overrun", O_R1P, 3, 1);
      cycle(1, 0);  chk_all("swap_once", O_R2, 3, 1);
      cycle(1, 0);  chk_all("no_second_swap", O_R2, 4, 1);

      cycle(0, 1);  chk_all("pending_before_reset", O_R2P, 4, 1);
      reset = 1'b0;
      cycle(1, 1);  chk_all("reset_mid_run", O_IDLE, 0, 0);
      reset = 1'b1;

      cycle(0, 0);  chk_all("restart", O_START, 0, 0);
      cycle(1, 0);
      cycle(1, 0);
      cycle(1, 0);  chk_all("restart_p3", O_START, 0, 0);
      cycle(1, 0);  chk_all("restart_fill", O_FILL, 0, 0);
      cycle(0, 1);  chk_all("restart_run", O_R1, 0, 0);
      cycle(1, 0);  chk_all("restart_repeat", O_R1, 1, 0);
      cycle(0, 1);  chk_all("restart_pending", O_R1P, 1, 0);

      start = 1'b0;
      cycle(0, 0);  chk_all("stop_idle_hold", O_IDLE, 1, 0);
      start = 1'b1;
      cycle(0, 0);  chk_all("again_startup", O_START, 1, 0);
      cycle(1, 0);
      cycle(1, 0);
      cycle(1, 0);
      cycle(1, 0);  chk_all("again_fill", O_FILL, 1, 0);
      cycle(0, 1);  chk_all("again_run", O_R1, 1, 0);
      cycle(1, 0);  chk_all("pending_cleared", O_R1, 2, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/frame_bank_scheduler.md
FRAME_BANK_SCHEDULER -- requirements
Module: frame_bank_scheduler

Interface
REQ-001 Parameter STARTUP_FRAMES, default 4: number of VGA frames held in forced-white startup mode.
REQ-002 Parameter CNT_W, default 16: width of the statistics counter.
REQ-003 CLK_40  input  1  single 40 MHz clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  level; high enables playback sequencing; low returns the block to IDLE.
REQ-006 frame_start  input  1  one-cycle pulse at the VGA frame boundary (scan position wraps to 0,0).
REQ-007 frame_write_done  input  1  one-cycle pulse when the memory write tracker completes a full scaled frame.
REQ-008 read_bank1  output  1  bank 1 is the display (read) bank.
REQ-009 read_bank2  output  1  bank 2 is the display (read) bank.
REQ-010 write_sel  output  1  write target: 0 = bank 1, 1 = bank 2.
REQ-011 write_ready  output  1  writer may stream pixel data into the write_sel bank.
REQ-012 VGA_en  output  1  VGA timing counters enabled.
REQ-013 VGA_startup_en  output  1  force pixel colour white.
REQ-014 repeat_count  output  CNT_W  frames redisplayed because no new frame was ready.
REQ-015 overrun  output  1  sticky; writer completed a frame while a swap was already pending.

Function
REQ-016 FSM states SHALL be IDLE, STARTUP, FILL and RUN; all outputs registered, changing one cycle after the causing input edge.
REQ-017 IDLE: VGA_en=0, read_bank1=read_bank2=0, write_ready=0, write_sel=0; start=1 -> STARTUP.
REQ-018 STARTUP: VGA_en=1, VGA_startup_en=1, write_ready=0; count frame_start pulses; after STARTUP_FRAMES pulses -> FILL.
REQ-019 FILL: VGA_en=1, VGA_startup_en=1, write_sel=0, write_ready=1; frame_write_done -> RUN with read_bank1=1, write_sel=1, pending=0.
REQ-020 RUN: VGA_startup_en=0; exactly one of read_bank1/read_bank2 high; write_sel always selects the other bank.
REQ-021 RUN: frame_write_done SHALL set internal pending and drop write_ready until the next swap.
REQ-022 RUN: frame_start with pending=1 SHALL swap display and write banks, clear pending, and raise write_ready.
REQ-023 RUN: frame_start with pending=0 SHALL keep banks unchanged and increment repeat_count, saturating at all-ones.
REQ-024 Same-cycle frame_write_done and frame_start in RUN SHALL be treated as done-then-start: swap occurs, repeat_count unchanged.
REQ-025 frame_write_done while pending=1 SHALL set overrun and SHALL NOT change banks or pending.
REQ-026 frame_write_done in IDLE or STARTUP SHALL be ignored.
REQ-027 The bank being read SHALL never equal write_sel while write_ready=1.
REQ-028 start=0 in any state SHALL return to IDLE on the next edge and clear pending; repeat_count and overrun SHALL be held.

Reset
REQ-029 reset=0 at an edge SHALL force IDLE, with all outputs 0, pending=0, the startup counter at 0, repeat_count=0 and overrun=0; this applies mid-frame as well as at power-up.
REQ-030 reset has priority over start and all pulse inputs.

Configuration
REQ-031 Macro FRAME_STATS_EN defined: repeat_count and overrun SHALL operate as specified.
REQ-032 FRAME_STATS_EN undefined: repeat_count SHALL be constant 0, overrun SHALL be constant 0, and no counter registers SHALL be synthesised; sequencing SHALL be unaffected.

Verification
REQ-033 Reset, start=1, 4 frame_start pulses -> VGA_startup_en=1 throughout, FILL entered one cycle after the 4th pulse, write_ready=1, write_sel=0.
REQ-034 FILL then frame_write_done -> read_bank1=1, write_sel=1 next cycle; then done + frame_start -> read_bank2=1, write_sel=0.
REQ-035 RUN, 3 frame_start pulses without done -> banks unchanged, repeat_count=3; with FRAME_STATS_EN undefined -> repeat_count=0.
REQ-036 RUN, two frame_write_done before a frame_start -> overrun=1 and write_ready=0; next frame_start swaps once.
REQ-037 Same-cycle frame_write_done and frame_start -> swap, repeat_count unchanged.
REQ-038 reset=0 mid-RUN with pending=1 -> next cycle IDLE, all outputs 0; start=0 mid-RUN -> IDLE, with repeat_count held.
